// File: rtl/axil_csr_responder.sv
// AXI4-Lite responder exposing a bank of RW control registers and RO status words.
// Write and read channels are independent, each with one outstanding transaction.
module axil_csr_responder #(
  parameter int addr_width_p = 10,
  parameter int data_width_p = 32,
  parameter int num_rw_p     = 8,
  parameter int num_ro_p     = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [addr_width_p-1:0]          awaddr_i,
  input  logic [2:0]                       awprot_i,
  input  logic                             awvalid_i,
  output logic                             awready_o,
  input  logic [data_width_p-1:0]          wdata_i,
  input  logic [data_width_p/8-1:0]        wstrb_i,
  input  logic                             wvalid_i,
  output logic                             wready_o,
  output logic [1:0]                       bresp_o,
  output logic                             bvalid_o,
  input  logic                             bready_i,
  input  logic [addr_width_p-1:0]          araddr_i,
  input  logic [2:0]                       arprot_i,
  input  logic                             arvalid_i,
  output logic                             arready_o,
  output logic [data_width_p-1:0]          rdata_o,
  output logic [1:0]                       rresp_o,
  output logic                             rvalid_o,
  input  logic                             rready_i,
  output logic [num_rw_p*data_width_p-1:0] rw_data_o,
  output logic [num_rw_p-1:0]              rw_wr_o,
  input  logic [num_ro_p*data_width_p-1:0] ro_data_i
);

  localparam int idx_w_lp  = addr_width_p - 2;
  localparam int strb_w_lp = data_width_p / 8;
  localparam logic [idx_w_lp-1:0] rw_end_lp = idx_w_lp'(num_rw_p);
  localparam logic [idx_w_lp-1:0] ro_end_lp = idx_w_lp'(num_rw_p + num_ro_p);

  typedef enum logic [1:0] {TGT_RW, TGT_RO, TGT_UNMAPPED} tgt_e;

  function automatic tgt_e decode(input logic [idx_w_lp-1:0] idx);
    if (idx < rw_end_lp) begin
      return TGT_RW;
    end else if (idx < ro_end_lp) begin
      return TGT_RO;
    end else begin
      return TGT_UNMAPPED;
    end
  endfunction

  logic                    aw_full_q, aw_full_d;
  logic [idx_w_lp-1:0]     aw_idx_q, aw_idx_d;
  logic                    w_full_q, w_full_d;
  logic [data_width_p-1:0] w_data_q, w_data_d;
  logic [strb_w_lp-1:0]    w_strb_q, w_strb_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    rvalid_q, rvalid_d;
  logic [data_width_p-1:0] rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [num_rw_p-1:0]     rw_wr_q, rw_wr_d;
  logic [data_width_p-1:0] rw_q [num_rw_p];
  logic [data_width_p-1:0] rw_d [num_rw_p];
  logic [idx_w_lp-1:0]     ar_idx_s;
  logic                    unused_s;

  assign awready_o = ~aw_full_q & ~bvalid_q;
  assign wready_o  = ~w_full_q & ~bvalid_q;
  assign arready_o = ~rvalid_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign rw_wr_o   = rw_wr_q;
  assign ar_idx_s  = araddr_i[addr_width_p-1:2];
  assign unused_s  = ^{awprot_i, arprot_i, awaddr_i[1:0], araddr_i[1:0]};

  for (genvar k = 0; k < num_rw_p; k++) begin : g_rw_out
    assign rw_data_o[k*data_width_p +: data_width_p] = rw_q[k];
  end

  // Next-state logic for both channels and the register bank
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rw_wr_d   = '0;
    rw_d      = rw_q;

    if (awvalid_i && awready_o) begin
      aw_full_d = 1'b1;
      aw_idx_d  = awaddr_i[addr_width_p-1:2];
    end else begin
      aw_full_d = aw_full_q;
    end

    if (wvalid_i && wready_o) begin
      w_full_d = 1'b1;
      w_data_d = wdata_i;
      w_strb_d = wstrb_i;
    end else begin
      w_full_d = w_full_q;
    end

    if (bvalid_q && bready_i) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end

    // Commit: both buffers full; bvalid blocks further AW/W until the B handshake
    if (aw_full_q && w_full_q) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      case (decode(aw_idx_q))
        TGT_RW: begin
          bresp_d = 2'b00;
          for (int k = 0; k < num_rw_p; k++) begin
            if (aw_idx_q == idx_w_lp'(k)) begin
              rw_wr_d[k] = 1'b1;
              for (int b = 0; b < strb_w_lp; b++) begin
                rw_d[k][8*b +: 8] = w_strb_q[b] ? w_data_q[8*b +: 8] : rw_q[k][8*b +: 8];
              end
            end else begin
              rw_wr_d[k] = 1'b0;
            end
          end
        end
        TGT_RO:  bresp_d = 2'b10;
        default: bresp_d = 2'b11;
      endcase
    end else begin
      bresp_d = bresp_q;
    end

    if (rvalid_q && rready_i) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end

    // Read data is sampled from the pre-commit register value
    if (arvalid_i && arready_o) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      case (decode(ar_idx_s))
        TGT_RW: begin
          rresp_d = 2'b00;
          for (int k = 0; k < num_rw_p; k++) begin
            rdata_d = (ar_idx_s == idx_w_lp'(k)) ? rw_q[k] : rdata_d;
          end
        end
        TGT_RO: begin
          rresp_d = 2'b00;
          for (int j = 0; j < num_ro_p; j++) begin
            rdata_d = (ar_idx_s == rw_end_lp + idx_w_lp'(j)) ?
                      ro_data_i[j*data_width_p +: data_width_p] : rdata_d;
          end
        end
        default: rresp_d = 2'b11;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      rw_wr_q   <= '0;
      for (int k = 0; k < num_rw_p; k++) begin
        rw_q[k] <= '0;
      end
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rw_wr_q   <= rw_wr_d;
      for (int k = 0; k < num_rw_p; k++) begin
        rw_q[k] <= rw_d[k];
      end
    end
  end

endmodule

// File: tb/tb_axil_csr_responder.sv
// Directed self-checking bench for axil_csr_responder; inputs driven and outputs sampled on negedge.
module tb_axil_csr_responder;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic [9:0]   awaddr = 10'd0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = 32'd0;
  logic [3:0]   wstrb = 4'd0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [9:0]   araddr = 10'd0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [255:0] rw_data;
  logic [7:0]   rw_wr;
  logic [127:0] ro_data = {32'h3333_3333, 32'h2222_2222, 32'h0BAD_F00D, 32'hCAFE_0000};

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rw [8];
  logic [1:0]  resp;
  logic [7:0]  seen;
  logic [31:0] rd;

  always #5 clk = ~clk;

  axil_csr_responder dut (
    .clk_i(clk), .reset_i(reset_i),
    .awaddr_i(awaddr), .awprot_i(3'd0), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
    .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .araddr_i(araddr), .arprot_i(3'd0), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
    .rw_data_o(rw_data), .rw_wr_o(rw_wr), .ro_data_i(ro_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] r, output logic [7:0] wr_seen);
    int n = 0;
    logic aw_go, w_go;
    r = 2'bxx;
    wr_seen = 8'd0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    while ((awvalid || wvalid) && n < 20) begin
      aw_go = awvalid & awready;
      w_go  = wvalid & wready;
      @(negedge clk); n++;
      wr_seen |= rw_wr;
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid = 1'b0;
    end
    while (!bvalid && n < 40) begin
      @(negedge clk); n++;
      wr_seen |= rw_wr;
    end
    if (bvalid) begin
      r = bresp;
      bready = 1'b1;
      @(negedge clk);
      wr_seen |= rw_wr;
      bready = 1'b0;
    end else begin
      awvalid = 1'b0; wvalid = 1'b0;
      check("write_timeout", {31'd0, bvalid}, 32'd1);
    end
  endtask

  task automatic axi_read(input logic [9:0] addr, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    logic ar_go;
    d = 32'hxxxx_xxxx; r = 2'bxx;
    araddr = addr; arvalid = 1'b1;
    while (arvalid && n < 20) begin
      ar_go = arvalid & arready;
      @(negedge clk); n++;
      if (ar_go) arvalid = 1'b0;
    end
    while (!rvalid && n < 40) begin
      @(negedge clk); n++;
    end
    if (rvalid) begin
      d = rdata; r = rresp;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end else begin
      arvalid = 1'b0;
      check("read_timeout", {31'd0, rvalid}, 32'd1);
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) exp_rw[k] = 32'd0;

    // Reset held with a pending write on the bus: nothing may commit
    awaddr = 10'h004; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    repeat (3) @(negedge clk);
    reset_i = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rw1", rw_data[32 +: 32], 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rw_wr", {24'd0, rw_wr}, 32'd0);
    check("rst_bresp_rdata", {rdata[29:0], bresp}, 32'd0);

    // Basic write, cycle-exact
    awaddr = 10'h004; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("basic_bvalid_c1", {31'd0, bvalid}, 32'd0);
    check("basic_awready_c1", {31'd0, awready}, 32'd0);
    @(negedge clk);
    check("basic_bvalid_c2", {31'd0, bvalid}, 32'd1);
    check("basic_bresp", {30'd0, bresp}, 32'd0);
    check("basic_pulse", {24'd0, rw_wr}, 32'h02);
    check("basic_data", rw_data[32 +: 32], 32'hDEAD_BEEF);
    exp_rw[1] = 32'hDEAD_BEEF;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("basic_bvalid_clr", {31'd0, bvalid}, 32'd0);
    check("basic_pulse_end", {24'd0, rw_wr}, 32'h00);
    check("basic_awready_back", {31'd0, awready}, 32'd1);
    axi_read(10'h004, rd, resp);
    check("basic_rdata", rd, 32'hDEAD_BEEF);
    check("basic_rresp", {30'd0, resp}, 32'd0);

    // W three cycles ahead of AW, partial strobes
    axi_write(10'h000, 32'hAAAA_AAAA, 4'hF, resp, seen);
    check("ord_init_bresp", {30'd0, resp}, 32'd0);
    check("ord_init_pulse", {24'd0, seen}, 32'h01);
    wdata = 32'h1122_3344; wstrb = 4'h5; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("ord_wready_wait", {31'd0, wready}, 32'd0);
      check("ord_no_early_b", {31'd0, bvalid}, 32'd0);
      @(negedge clk);
    end
    awaddr = 10'h000; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("ord_wready_commit", {31'd0, wready}, 32'd0);
    @(negedge clk);
    check("ord_bvalid", {31'd0, bvalid}, 32'd1);
    check("ord_wready_b", {31'd0, wready}, 32'd0);
    check("ord_data", rw_data[0 +: 32], 32'hAA22_AA44);
    exp_rw[0] = 32'hAA22_AA44;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("ord_wready_free", {31'd0, wready}, 32'd1);

    // Write-response backpressure
    awaddr = 10'h00C; wdata = 32'h1234_5678; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    exp_rw[3] = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      check("bp_bvalid", {31'd0, bvalid}, 32'd1);
      check("bp_bresp", {30'd0, bresp}, 32'd0);
      check("bp_aw_w_ready", {30'd0, awready, wready}, 32'd0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bp_bvalid_clr", {31'd0, bvalid}, 32'd0);

    // Read-response backpressure
    araddr = 10'h00C; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp_rvalid", {31'd0, rvalid}, 32'd1);
      check("bp_rdata", rdata, 32'h1234_5678);
      check("bp_rresp_arready", {29'd0, rresp, arready}, 32'd0);
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("bp_rvalid_clr", {31'd0, rvalid}, 32'd0);
    check("bp_arready_back", {31'd0, arready}, 32'd1);

    // Error responses and status reads
    axi_write(10'h020, 32'hFFFF_FFFF, 4'hF, resp, seen);
    check("ro_wr_bresp", {30'd0, resp}, 32'h2);
    check("ro_wr_no_pulse", {24'd0, seen}, 32'h00);
    axi_write(10'h3FC, 32'hFFFF_FFFF, 4'hF, resp, seen);
    check("unm_wr_bresp", {30'd0, resp}, 32'h3);
    check("unm_wr_no_pulse", {24'd0, seen}, 32'h00);
    axi_read(10'h3FC, rd, resp);
    check("unm_rd_data", rd, 32'd0);
    check("unm_rd_rresp", {30'd0, resp}, 32'h3);
    axi_read(10'h024, rd, resp);
    check("ro1_rd_data", rd, 32'h0BAD_F00D);
    check("ro1_rd_rresp", {30'd0, resp}, 32'd0);
    axi_read(10'h02C, rd, resp);
    check("ro3_rd_data", rd, 32'h3333_3333);
    axi_write(10'h004, 32'h0000_0000, 4'h0, resp, seen);
    check("strb0_bresp", {30'd0, resp}, 32'd0);
    check("strb0_pulse", {24'd0, seen}, 32'h02);

    // Read/write collision on reg2
    axi_write(10'h008, 32'd5, 4'hF, resp, seen);
    awaddr = 10'h008; wdata = 32'd9; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 10'h008; arvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    check("col_rvalid", {31'd0, rvalid}, 32'd1);
    check("col_old_value", rdata, 32'd5);
    check("col_new_reg", rw_data[64 +: 32], 32'd9);
    exp_rw[2] = 32'd9;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    check("col_b_r_done", {30'd0, bvalid, rvalid}, 32'd0);
    axi_read(10'h008, rd, resp);
    check("col_new_value", rd, 32'd9);

    // Final register bank against the bench model
    for (int k = 0; k < 8; k++) begin
      check($sformatf("final_rw%0d", k), rw_data[k*32 +: 32], exp_rw[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
